// File: rtl/imem_loader.sv
// Boot-time loader: assembles a framed big-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until the XOR checksum matches.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_error
);

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t              state_r;
  logic [15:0]         n_r;
  logic [ADDR_WIDTH:0] index_r;
  logic [1:0]          byte_cnt_r;
  logic [23:0]         word_r;
  logic [7:0]          chk_r;

  logic                accept_s;
  logic [15:0]         n_full_s;
  logic [16:0]         next_index_s;

  assign accept_s     = rx_valid && rx_ready;
  assign n_full_s     = {n_r[15:8], rx_data};
  assign next_index_s = 17'(index_r) + 17'd1;

  // Frame-parsing state machine with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= HDR_HI;
      n_r        <= 16'd0;
      index_r    <= '0;
      byte_cnt_r <= 2'd0;
      word_r     <= 24'd0;
      chk_r      <= 8'd0;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state_r)
        HDR_HI: begin
          if (accept_s) begin
            n_r[15:8] <= rx_data;
            state_r   <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept_s) begin
            n_r[7:0] <= rx_data;
            if ({1'b0, n_full_s} > DEPTH) begin
              state_r    <= ERROR;
              rx_ready   <= 1'b0;
              load_error <= 1'b1;
            end else if (n_full_s == 16'd0) begin
              state_r <= CHECK;
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_s) begin
            chk_r <= chk_update(chk_r, rx_data);
            if (byte_cnt_r == 2'd3) begin
              // Fourth byte completes the word; the write is presented next cycle.
              imem_we    <= 1'b1;
              imem_addr  <= index_r[ADDR_WIDTH-1:0];
              imem_wdata <= {word_r, rx_data};
              index_r    <= index_r + 1'b1;
              byte_cnt_r <= 2'd0;
              if (next_index_s == {1'b0, n_r}) begin
                state_r <= CHECK;
              end
            end else begin
              word_r     <= {word_r[15:0], rx_data};
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end
          end
        end
        CHECK: begin
          if (accept_s) begin
            rx_ready <= 1'b0;
            if (rx_data == chk_r) begin
              state_r    <= DONE;
              core_reset <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              state_r    <= ERROR;
              load_error <= 1'b1;
            end
          end
        end
        DONE, ERROR: begin
          if (start) begin
            state_r    <= HDR_HI;
            index_r    <= '0;
            byte_cnt_r <= 2'd0;
            chk_r      <= 8'd0;
            rx_ready   <= 1'b1;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
          end
        end
        default: begin
          state_r    <= HDR_HI;
          index_r    <= '0;
          byte_cnt_r <= 2'd0;
          chk_r      <= 8'd0;
          rx_ready   <= 1'b1;
          core_reset <= 1'b1;
          load_done  <= 1'b0;
          load_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and popped by a negedge monitor whenever imem_we is seen.
module tb_imem_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          load_done;
  logic          load_error;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .start(start), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_writes++;
      if (exp_data_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(ea));
        check("write_data", imem_wdata, ed);
      end
    end
  end

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // Present one byte after 'gap' idle cycles; returns at the negedge after it transfers.
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got rx_ready %b expected 1 for byte %h", rx_ready, b);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send(w[31:24], gap);
    send(w[23:16], 0);
    send(w[15:8], 0);
    send(w[7:0], 0);
  endtask

  task automatic check_status(input string name, input logic done, input logic err,
                              input logic cr, input logic rdy);
    check({name, "_done"}, 32'(load_done), 32'(done));
    check({name, "_error"}, 32'(load_error), 32'(err));
    check({name, "_core_reset"}, 32'(core_reset), 32'(cr));
    check({name, "_rx_ready"}, 32'(rx_ready), 32'(rdy));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check_status(name, 1'b0, 1'b0, 1'b1, 1'b1);
    check({name, "_we"}, 32'(imem_we), 32'd0);
    check({name, "_addr"}, 32'(imem_addr), 32'd0);
    check({name, "_wdata"}, imem_wdata, 32'd0);
  endtask

  initial begin
    int gaps[8];
    int w0;
    logic [7:0]  cs;
    logic [31:0] w;
    gaps = '{0, 2, 1, 0, 3, 0, 1, 2};

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; start = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single word, good checksum
    expect_write(4'd0, 32'h2008_0005);
    send(8'h00, 0); send(8'h01, 0);
    send_word(32'h2008_0005, 0);
    check("single_core_reset_loading", 32'(core_reset), 32'd1);
    send(8'h2D, 0);
    check_status("single", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();
    check_status("rearm1", 1'b0, 1'b0, 1'b1, 1'b1);

    // Bad checksum: write still happens, then error
    expect_write(4'd0, 32'h2008_0005);
    send(8'h00, 0); send(8'h01, 0);
    send_word(32'h2008_0005, 0);
    send(8'h2C, 0);
    check_status("badsum", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_start();

    // Empty program
    w0 = n_writes;
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    check_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);
    check("empty_no_writes", 32'(n_writes - w0), 32'd0);
    pulse_start();

    // Oversize header: 17 words with a 16-word memory
    w0 = n_writes;
    send(8'h00, 0); send(8'h11, 0);
    check_status("oversize", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("oversize_no_writes", 32'(n_writes - w0), 32'd0);
    pulse_start();

    // Two words with rx_valid gaps
    expect_write(4'd0, 32'h8C09_0000);
    expect_write(4'd1, 32'hAC09_0004);
    send(8'h00, 1); send(8'h02, 2);
    for (int i = 0; i < 4; i++) send(8'(32'h8C09_0000 >> (24 - 8 * i)), gaps[i]);
    for (int i = 0; i < 4; i++) send(8'(32'hAC09_0004 >> (24 - 8 * i)), gaps[i + 4]);
    send(8'h24, 3);
    check_status("gaps", 1'b1, 1'b0, 1'b0, 1'b0);

    // Re-arm from DONE and load a zero word
    pulse_start();
    check("rearm_core_reset_high", 32'(core_reset), 32'd1);
    expect_write(4'd0, 32'h0000_0000);
    send(8'h00, 0); send(8'h01, 0);
    send_word(32'h0000_0000, 0);
    send(8'h00, 0);
    check_status("zero_word", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();

    // Reset after two payload bytes, then a fresh frame from address 0
    send(8'h00, 0); send(8'h01, 0);
    send(8'hDE, 0); send(8'hAD, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    expect_write(4'd0, 32'h1234_5678);
    send(8'h00, 0); send(8'h01, 0);
    send_word(32'h1234_5678, 0);
    send(8'h08, 0);
    check_status("after_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();

    // Exactly full memory: 16 words
    cs = 8'h00;
    send(8'h00, 0); send(8'h10, 0);
    for (int i = 0; i < 16; i++) begin
      w = {8'(i), 8'hA5, 8'(3 * i), 8'h5A};
      cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      expect_write(4'(i), w);
      send_word(w, i % 2);
    end
    send(cs, 0);
    check_status("full", 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_data_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader directly upstream of the single-cycle MIPS core's instruction memory.
- Accepts a framed byte stream over a valid/ready interface and assembles big-endian 32-bit words.
- Writes each word into instruction memory at sequential word addresses, then verifies an XOR checksum.
- Holds the core in reset until a load completes without error.

Parameters:
- ADDR_WIDTH, 8: instruction memory word-address width; depth = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready.
- start  input  1  single-cycle pulse that re-arms the loader from DONE or ERROR.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  word to write.
- core_reset  output  1  reset to the MIPS core; high while loading or in error.
- load_done  output  1  load completed and checksum matched.
- load_error  output  1  checksum mismatch or oversize word count.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Frame format:
  - 2-byte word count N, high byte first.
  - 4*N payload bytes; each word is big-endian, so the first byte is bits 31:24.
  - 1 checksum byte equal to the XOR of all payload bytes. Header bytes are excluded.
- Reset values: state=HDR_HI, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, load_done=0, load_error=0, byte index=0, checksum accumulator=0.
- States:
  - HDR_HI: accept byte into N[15:8]; go to HDR_LO.
  - HDR_LO: accept byte into N[7:0].
    - If N > 2**ADDR_WIDTH, go to ERROR.
    - If N == 0, go to CHECK.
    - Otherwise go to DATA.
  - DATA: shift each accepted byte into the word register and XOR it into the checksum.
    - On the 4th byte of a word, the next cycle drives imem_we=1 with imem_addr = word index and imem_wdata = the assembled word. This is registered, one-cycle latency.
    - The word index then increments.
    - After word N-1's 4th byte, go to CHECK.
  - CHECK: accept one byte.
    - If it equals the accumulator, go to DONE; otherwise go to ERROR.
  - DONE: rx_ready=0, core_reset=0, load_done=1.
  - ERROR: rx_ready=0, core_reset=1, load_error=1.
- rx_ready is 1 in HDR_HI, HDR_LO, DATA and CHECK, and 0 in DONE and ERROR.
- Gaps in rx_valid stall the state machine with no state change. No byte is lost or duplicated.
- imem_we is high for exactly one cycle per word and never outside DATA or the cycle following DATA.
- The last word's write completes before DONE is entered; load_done and core_reset deassertion lag the last write by at least 1 cycle.
- start in DONE or ERROR returns the loader to HDR_HI and clears the checksum, index, load_done and load_error. core_reset reasserts in the same cycle the state changes. start is ignored in all other states.
- Reset mid-load discards the partial word and returns to the reset values. Memory contents already written are not cleared.
- Word index width is ADDR_WIDTH+1 internally. imem_addr = index[ADDR_WIDTH-1:0]; no wrap can occur because N ≤ depth.

Test Plan:
- Single word: stream 00 01 20 08 00 05 2D.
  - Required: one imem_we pulse with addr=0, wdata=0x20080005.
  - Then load_done=1, core_reset=0, rx_ready=0.
- Bad checksum: same stream with last byte 2C.
  - Required: write still occurs; then load_error=1, core_reset stays 1, load_done=0.
- Empty program: 00 00 00.
  - Required: no imem_we; load_done=1.
- Oversize, with ADDR_WIDTH=4: header 00 11 (N=17).
  - Required: load_error=1 and rx_ready=0 the cycle after the second byte; no writes.
- Two words 0x8C090000, 0xAC090004 with random rx_valid gaps (checksum 0x24).
  - Required: writes to addr 0 then 1 with exact data; done.
- Re-arm and reset:
  - After DONE, pulse start and load one word 0x00000000 (checksum 00). Required: core_reset goes high then low, addr restarts at 0.
  - Assert reset after 2 payload bytes. Required: all outputs return to reset values, and the next frame writes from addr 0.
